// File: rtl/pong_pkg.sv
// Shared game constants and paddle FSM encodings.
// The ball logic, the paddle position block and paddle_ctrl all import this package.
// It has no ports.
package pong_pkg;

  localparam int MAX_X         = 640;
  localparam int MAX_Y         = 480;
  localparam int WALL_SIZE     = 16;
  localparam int PADDLE_HEIGHT = 64;

  // The numeric values are visible on the debug state port and must stay fixed.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } paddle_state_t;

  // Movement request produced by the per-cycle decode.
  typedef enum logic [1:0] {
    REQ_NONE = 2'd0,
    REQ_UP   = 2'd1,
    REQ_DOWN = 2'd2
  } paddle_req_t;

endpackage

// File: rtl/btn_debounce.sv
// Debounces one raw asynchronous push button.
// The button first passes through a 2-FF synchroniser.
// The debounced level follows the synchronised sample only after the sample has
// disagreed with the level for DB_CYCLES consecutive clocks.
// The total latency from raw input to debounced level is 2 + DB_CYCLES cycles.
// Ports:
//   clk    system clock
//   rst_n  synchronous reset, active low
//   raw    raw button, active high, asynchronous
//   level  debounced button level
module btn_debounce #(
  parameter int DB_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level
);

  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

  logic          sync_p0;
  logic          sync_p1;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      cnt     <= '0;
      level   <= 1'b0;
    end else begin
      // synchroniser stage 0 -> 1
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
      // debounce stage: any agreeing sample restarts the stability count
      if (sync_p1 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DB_CYCLES - 1)) begin
        level <= sync_p1;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/paddle_ctrl.sv
// Paddle sequencer.
// It turns debounced player buttons, or auto-tracking of ball_y, into rate-limited
// single-cycle up/down move pulses.
// Manual input always overrides auto-tracking.
// Range limiting is left to the paddle position block.
// Ports:
//   clk       system clock
//   rst_n     synchronous reset, active low
//   btn_up    raw up button, active high
//   btn_down  raw down button, active high
//   auto_en   track ball_y when no button is held
//   ball_y    ball top y, in pixels
//   paddle_y  current paddle top y, in pixels
//   up        one-cycle move-up pulse
//   down      one-cycle move-down pulse
//   state     FSM state for debug: 0 IDLE, 1 UP, 2 DOWN
module paddle_ctrl
  import pong_pkg::*;
#(
  parameter int STEP_DIV  = 100000,
  parameter int DB_CYCLES = 50000,
  parameter int HEIGHT    = pong_pkg::PADDLE_HEIGHT,
  parameter int DEADBAND  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       auto_en,
  input  logic [9:0] ball_y,
  input  logic [9:0] paddle_y,
  output logic       up,
  output logic       down,
  output logic [1:0] state
);

  localparam int SW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

  logic          db_up;
  logic          db_down;
  logic [SW-1:0] step_cnt;
  logic          tick;
  logic [10:0]   centre;
  logic [10:0]   ball_ext;
  paddle_req_t   req;
  paddle_state_t state_q;
  paddle_state_t next_state;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_up (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (btn_up),
    .level (db_up)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_down (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (btn_down),
    .level (db_down)
  );

  assign tick = (step_cnt == SW'(STEP_DIV - 1));

  // The decode uses 11 bits so that paddle_y + HEIGHT/2 + DEADBAND cannot wrap.
  assign centre   = {1'b0, paddle_y} + 11'(HEIGHT / 2);
  assign ball_ext = {1'b0, ball_y};

  always_comb begin
    req = REQ_NONE;
    if (db_up && !db_down) begin
      req = REQ_UP;
    end else if (db_down && !db_up) begin
      req = REQ_DOWN;
    end else if (!db_up && !db_down && auto_en) begin
      // When both buttons are held, auto-tracking is deliberately skipped.
      if (ball_ext + 11'(DEADBAND) < centre) begin
        req = REQ_UP;
      end else if (ball_ext > centre + 11'(DEADBAND)) begin
        req = REQ_DOWN;
      end
    end
  end

  // Any state may go straight to any other state, including UP <-> DOWN.
  always_comb begin
    next_state = IDLE;
    case (req)
      REQ_UP:   next_state = UP;
      REQ_DOWN: next_state = DOWN;
      default:  next_state = IDLE;
    endcase
  end

  // step / FSM / pulse register stage
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      step_cnt <= '0;
      state_q  <= IDLE;
      up       <= 1'b0;
      down     <= 1'b0;
    end else begin
      step_cnt <= tick ? '0 : step_cnt + 1'b1;
      if (tick) begin
        state_q <= next_state;
      end
      up   <= tick && (next_state == UP);
      down <= tick && (next_state == DOWN);
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_paddle_ctrl.sv
// Self-checking bench for paddle_ctrl.
// It uses a small parameter set: STEP_DIV=4, DB_CYCLES=3, HEIGHT=64, DEADBAND=4.
// A cycle model pushes the expected {up, down, state} onto a scoreboard queue
// before each clock edge. Each scenario pops the queue after the edge and compares.
// Each scenario also checks timing and pulse-count figures derived from the
// behaviour description.
module tb_paddle_ctrl;

  localparam int STEP_DIV  = 4;
  localparam int DB_CYCLES = 3;
  localparam int HEIGHT    = 64;
  localparam int DEADBAND  = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_up = 1'b0;
  logic       btn_down = 1'b0;
  logic       auto_en = 1'b0;
  logic [9:0] ball_y = '0;
  logic [9:0] paddle_y = '0;
  logic       up;
  logic       down;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;
  int cyc_n  = 0;

  logic [3:0] sb[$];

  // reference model state
  logic       mu_f1 = 1'b0, mu_f2 = 1'b0, mu_lvl = 1'b0;
  logic       md_f1 = 1'b0, md_f2 = 1'b0, md_lvl = 1'b0;
  int         mu_cnt = 0, md_cnt = 0, m_step = 0;
  logic [1:0] m_state = 2'd0;
  logic       m_up = 1'b0, m_down = 1'b0;

  always #5 clk = ~clk;

  paddle_ctrl #(
    .STEP_DIV  (STEP_DIV),
    .DB_CYCLES (DB_CYCLES),
    .HEIGHT    (HEIGHT),
    .DEADBAND  (DEADBAND)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_up   (btn_up),
    .btn_down (btn_down),
    .auto_en  (auto_en),
    .ball_y   (ball_y),
    .paddle_y (paddle_y),
    .up       (up),
    .down     (down),
    .state    (state)
  );

  // Evaluate the model for the coming edge and push the expected outputs.
  task automatic model_edge();
    int req;
    int centre;
    int b;
    if (!rst_n) begin
      mu_f1 = 0; mu_f2 = 0; mu_lvl = 0; mu_cnt = 0;
      md_f1 = 0; md_f2 = 0; md_lvl = 0; md_cnt = 0;
      m_step = 0; m_state = 2'd0; m_up = 0; m_down = 0;
    end else begin
      req = 0;
      if (mu_lvl && !md_lvl) req = 1;
      else if (md_lvl && !mu_lvl) req = 2;
      else if (!mu_lvl && !md_lvl && auto_en) begin
        centre = int'(paddle_y) + HEIGHT / 2;
        b = int'(ball_y);
        if (b + DEADBAND < centre) req = 1;
        else if (b > centre + DEADBAND) req = 2;
      end
      if (m_step == STEP_DIV - 1) begin
        m_step = 0;
        m_state = 2'(req);
        m_up = (req == 1);
        m_down = (req == 2);
      end else begin
        m_step++;
        m_up = 0;
        m_down = 0;
      end
      if (mu_f2 == mu_lvl) mu_cnt = 0;
      else if (mu_cnt == DB_CYCLES - 1) begin mu_lvl = mu_f2; mu_cnt = 0; end
      else mu_cnt++;
      mu_f2 = mu_f1; mu_f1 = btn_up;
      if (md_f2 == md_lvl) md_cnt = 0;
      else if (md_cnt == DB_CYCLES - 1) begin md_lvl = md_f2; md_cnt = 0; end
      else md_cnt++;
      md_f2 = md_f1; md_f1 = btn_down;
    end
    sb.push_back({m_up, m_down, m_state});
  endtask

  task automatic cyc();
    model_edge();
    @(posedge clk);
    #1;
    cyc_n++;
  endtask

  // Reset cycles between scenarios; scoreboard entries are dropped unchecked.
  task automatic quiet_reset();
    logic [3:0] e;
    rst_n = 1'b0;
    btn_up = 1'b0; btn_down = 1'b0; auto_en = 1'b0;
    repeat (2) begin cyc(); e = sb.pop_front(); end
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [3:0] e;
    int first, second;
    rst_n = 1'b0; btn_up = 1'b1; btn_down = 1'b0; auto_en = 1'b0;
    repeat (10) begin
      cyc(); e = sb.pop_front();
      checks++;
      if ({up, down, state} !== e) begin
        errors++;
        $display("FAIL reset_sb cyc=%0d got %b%b/%0d exp %b", cyc_n, up, down, state, e);
      end
      checks++;
      if ({up, down, state} !== 4'b0) begin
        errors++;
        $display("FAIL reset_zero cyc=%0d got %b%b/%0d exp 00/0", cyc_n, up, down, state);
      end
    end
    rst_n = 1'b1;
    first = -1; second = -1;
    for (int i = 1; i <= 16; i++) begin
      cyc(); e = sb.pop_front();
      checks++;
      if ({up, down, state} !== e) begin
        errors++;
        $display("FAIL release_sb cyc=%0d got %b%b/%0d exp %b", cyc_n, up, down, state, e);
      end
      if (up === 1'b1 && first < 0) first = i;
      else if (up === 1'b1 && second < 0) second = i;
    end
    checks++;
    if (first != 8) begin
      errors++;
      $display("FAIL first_up_latency got %0d exp 8", first);
    end
    checks++;
    if (second - first != STEP_DIV) begin
      errors++;
      $display("FAIL up_period got %0d exp %0d", second - first, STEP_DIV);
    end
  endtask

  task automatic test_glitch();
    logic [3:0] e;
    int ups, downs, last, gap_bad;
    quiet_reset();
    btn_down = 1'b1;
    ups = 0; downs = 0;
    for (int i = 0; i < 22; i++) begin
      if (i == 2) btn_down = 1'b0;
      cyc(); e = sb.pop_front();
      checks++;
      if ({up, down, state} !== e) begin
        errors++;
        $display("FAIL glitch_sb cyc=%0d got %b%b/%0d exp %b", cyc_n, up, down, state, e);
      end
      ups += int'(up); downs += int'(down);
    end
    checks++;
    if (ups != 0 || downs != 0) begin
      errors++;
      $display("FAIL glitch_pulses got up=%0d down=%0d exp 0 0", ups, downs);
    end
    btn_down = 1'b1;
    ups = 0; downs = 0; last = -1; gap_bad = 0;
    for (int i = 1; i <= 24; i++) begin
      cyc(); e = sb.pop_front();
      checks++;
      if ({up, down, state} !== e) begin
        errors++;
        $display("FAIL hold_down_sb cyc=%0d got %b%b/%0d exp %b", cyc_n, up, down, state, e);
      end
      ups += int'(up);
      if (down === 1'b1) begin
        if (last >= 0 && i - last != STEP_DIV) gap_bad++;
        last = i; downs++;
      end
    end
    checks++;
    if (downs < 4 || ups != 0 || gap_bad != 0) begin
      errors++;
      $display("FAIL hold_down_train got down=%0d up=%0d badgap=%0d exp >=4 0 0", downs, ups, gap_bad);
    end
    checks++;
    if (state !== 2'd2) begin
      errors++;
      $display("FAIL hold_down_state got %0d exp 2", state);
    end
    btn_down = 1'b0;
  endtask

  task automatic test_both();
    logic [3:0] e;
    int pulses;
    quiet_reset();
    btn_up = 1'b1; btn_down = 1'b1; auto_en = 1'b1;
    ball_y = 10'd0; paddle_y = 10'd200;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(); e = sb.pop_front();
      checks++;
      if ({up, down, state} !== e) begin
        errors++;
        $display("FAIL both_sb cyc=%0d got %b%b/%0d exp %b", cyc_n, up, down, state, e);
      end
      if (i >= 8) pulses += int'(up) + int'(down);
    end
    checks++;
    if (pulses != 0 || state !== 2'd0) begin
      errors++;
      $display("FAIL both_conflict got pulses=%0d state=%0d exp 0 0", pulses, state);
    end
  endtask

  task automatic test_auto();
    logic [3:0] e;
    int ups, downs;
    int bvals [5] = '{100, 230, 236, 237, 237};
    int xup   [5] = '{2, 0, 0, 0, 0};
    int xdn   [5] = '{0, 0, 0, 2, 0};
    btn_up = 1'b0; btn_down = 1'b0; auto_en = 1'b1; paddle_y = 10'd200;
    for (int k = 0; k < 5; k++) begin
      ball_y = 10'(bvals[k]);
      if (k == 4) auto_en = 1'b0;
      ups = 0; downs = 0;
      for (int i = 0; i < ((k == 0) ? 20 : 12); i++) begin
        cyc(); e = sb.pop_front();
        checks++;
        if ({up, down, state} !== e) begin
          errors++;
          $display("FAIL auto_sb ball=%0d cyc=%0d got %b%b/%0d exp %b", bvals[k], cyc_n, up, down, state, e);
        end
        if (i >= ((k == 0) ? 12 : 4)) begin
          ups += int'(up); downs += int'(down);
        end
      end
      checks++;
      if (ups != xup[k] || downs != xdn[k]) begin
        errors++;
        $display("FAIL auto_count case=%0d ball=%0d got up=%0d down=%0d exp %0d %0d",
                 k, bvals[k], ups, downs, xup[k], xdn[k]);
      end
    end
  endtask

  task automatic test_override();
    logic [3:0] e;
    logic [1:0] prev;
    int found, idle_seen;
    auto_en = 1'b1; ball_y = 10'd400; paddle_y = 10'd200;
    btn_up = 1'b0; btn_down = 1'b0;
    repeat (8) begin
      cyc(); e = sb.pop_front();
      checks++;
      if ({up, down, state} !== e) begin
        errors++;
        $display("FAIL ovr_pre_sb cyc=%0d got %b%b/%0d exp %b", cyc_n, up, down, state, e);
      end
    end
    btn_up = 1'b1;
    found = 0; idle_seen = 0; prev = state;
    for (int i = 0; i < 20 && found == 0; i++) begin
      cyc(); e = sb.pop_front();
      checks++;
      if ({up, down, state} !== e) begin
        errors++;
        $display("FAIL ovr_press_sb cyc=%0d got %b%b/%0d exp %b", cyc_n, up, down, state, e);
      end
      if (state === 2'd0) idle_seen = 1;
      if (up === 1'b1) begin
        found = 1;
        checks++;
        if (prev !== 2'd2 || state !== 2'd1) begin
          errors++;
          $display("FAIL ovr_reversal got %0d->%0d exp 2->1", prev, state);
        end
      end
      prev = state;
    end
    checks++;
    if (found == 0 || idle_seen != 0) begin
      errors++;
      $display("FAIL ovr_up_pulse got found=%0d idle=%0d exp 1 0", found, idle_seen);
    end
    btn_up = 1'b0;
    found = 0; idle_seen = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      cyc(); e = sb.pop_front();
      checks++;
      if ({up, down, state} !== e) begin
        errors++;
        $display("FAIL ovr_release_sb cyc=%0d got %b%b/%0d exp %b", cyc_n, up, down, state, e);
      end
      if (state === 2'd0) idle_seen = 1;
      if (down === 1'b1) found = 1;
    end
    checks++;
    if (found == 0 || idle_seen != 0 || state !== 2'd2) begin
      errors++;
      $display("FAIL ovr_back_down got found=%0d idle=%0d state=%0d exp 1 0 2", found, idle_seen, state);
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] e;
    int first;
    auto_en = 1'b0; btn_down = 1'b0; btn_up = 1'b1;
    repeat (12) begin
      cyc(); e = sb.pop_front();
      checks++;
      if ({up, down, state} !== e) begin
        errors++;
        $display("FAIL mid_pre_sb cyc=%0d got %b%b/%0d exp %b", cyc_n, up, down, state, e);
      end
    end
    rst_n = 1'b0;
    cyc(); e = sb.pop_front();
    checks++;
    if ({up, down, state} !== 4'b0 || e !== 4'b0) begin
      errors++;
      $display("FAIL mid_reset_out got %b%b/%0d exp 00/0", up, down, state);
    end
    rst_n = 1'b1;
    first = -1;
    for (int i = 1; i <= 10; i++) begin
      cyc(); e = sb.pop_front();
      checks++;
      if ({up, down, state} !== e) begin
        errors++;
        $display("FAIL mid_post_sb cyc=%0d got %b%b/%0d exp %b", cyc_n, up, down, state, e);
      end
      if (up === 1'b1 && first < 0) first = i;
    end
    checks++;
    if (first != 8) begin
      errors++;
      $display("FAIL mid_first_up got %0d exp 8", first);
    end
    btn_up = 1'b0;
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_both();
    test_auto();
    test_override();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc_n);
    $fatal(1, "watchdog");
  end

endmodule
